// File: rtl/mem_bus_pkg.sv
// Shared encodings for the unified memory bus arbiter: owner one-hot codes,
// arbiter states and the byte-enable width.
package mem_bus_pkg;

  localparam int unsigned BE_WIDTH = 4;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between fetch (imem) and LSU (dmem).
// Data has priority, bounded by a starvation counter; grant locks across stalls.
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [BE_WIDTH-1:0]   imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  input  logic                  dmem_valid_i,
  output logic                  dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [BE_WIDTH-1:0]   dmem_we_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BE_WIDTH-1:0]   mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [1:0]            grant_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve;
  logic [1:0] owner;
  logic       owner_valid;
  logic       unused;

  // Fetch never writes; its write fields exist only for port symmetry.
  assign unused = ^{imem_wdata_i, imem_we_i};

  // Owner is forced to none during reset so every output reads 0 immediately.
  always_comb begin
    owner = GRANT_NONE;
    if (!rst) begin
      case (state)
        LOCK_I: owner = GRANT_I;
        LOCK_D: owner = GRANT_D;
        default: begin
          if (imem_valid_i && starve == LIMIT) owner = GRANT_I;
          else if (dmem_valid_i)               owner = GRANT_D;
          else if (imem_valid_i)               owner = GRANT_I;
        end
      endcase
    end
  end

  always_comb begin
    owner_valid  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = '0;
    if (owner == GRANT_I) begin
      owner_valid = imem_valid_i;
      mem_addr_o  = imem_addr_i;
    end else if (owner == GRANT_D) begin
      owner_valid = dmem_valid_i;
      mem_addr_o  = dmem_addr_i;
      mem_wdata_o = dmem_wdata_i;
      mem_we_o    = dmem_we_i;
    end
  end

  assign mem_valid_o  = owner_valid;
  assign grant_o      = owner;
  assign imem_ready_o = mem_ready_i && owner == GRANT_I && imem_valid_i;
  assign dmem_ready_o = mem_ready_i && owner == GRANT_D && dmem_valid_i;
  assign imem_rdata_o = rst ? '0 : mem_rdata_i;
  assign dmem_rdata_o = rst ? '0 : mem_rdata_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (owner_valid && !mem_ready_i)
            state <= (owner == GRANT_I) ? LOCK_I : LOCK_D;
        end
        LOCK_I: if (!imem_valid_i || mem_ready_i) state <= IDLE;
        LOCK_D: if (!dmem_valid_i || mem_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!imem_valid_i || imem_ready_o)
        starve <= '0;
      else if (owner != GRANT_I && starve != LIMIT)
        starve <= starve + 4'd1;
    end
  end

endmodule
